// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 transfer controller: request/response handshake around an external SCK generator.
// Optional SPI_XFER_LSB_FIRST_EN adds lsb_first_i for LSB-first shifting.
module spi_xfer_ctrl (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [4:0]  req_len_i,
   input  logic [31:0] req_tx_i,
`ifdef SPI_XFER_LSB_FIRST_EN
   input  logic        lsb_first_i,
`endif
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rx_o,
   input  logic [7:0]  div_i,
   input  logic        div_valid_i,
   output logic [7:0]  cg_div_o,
   output logic        cg_div_valid_o,
   output logic        cg_en_o,
   input  logic        cg_rise_i,
   input  logic        cg_fall_i,
   output logic        spi_csn_o,
   output logic        spi_sdo_o,
   input  logic        spi_sdi_i,
   output logic        busy_o
);

   typedef enum logic [2:0] {
      IDLE, SETUP, XFER, DRAIN, HOLD, RESP
   } state_t;

   state_t      state, nxt;
   logic [4:0]  len;
   logic [5:0]  cnt;
   logic [31:0] sh;
   logic [31:0] rx;
   logic        tick;
   logic        lsb;
   logic        last;
   logic        take;

   assign last = (cnt == {1'b0, len});
   assign take = (state == IDLE) && req_valid_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (req_valid_i)           nxt = SETUP;
         SETUP:   if (tick)                  nxt = XFER;
         XFER:    if (cg_rise_i && last)     nxt = DRAIN;
         DRAIN:   if (cg_fall_i)             nxt = HOLD;
         HOLD:    if (tick)                  nxt = RESP;
         RESP:    if (rsp_ready_i)           nxt = IDLE;
         default:                            nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      cg_en_o     = 1'b0;
      spi_csn_o   = 1'b1;
      busy_o      = 1'b1;
      unique case (state)
         IDLE: begin
            req_ready_o = !rst_i;
            busy_o      = 1'b0;
         end
         SETUP: spi_csn_o = 1'b0;
         XFER: begin
            spi_csn_o = 1'b0;
            cg_en_o   = 1'b1;
         end
         // the closing fall drops the enable in the same cycle it arrives
         DRAIN: begin
            spi_csn_o = 1'b0;
            cg_en_o   = !cg_fall_i;
         end
         HOLD: spi_csn_o = 1'b0;
         RESP: rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   assign rsp_rx_o       = rsp_valid_o ? rx : 32'd0;
   assign cg_div_o       = div_i;
   assign cg_div_valid_o = div_valid_i && req_ready_o;
   assign spi_sdo_o      = (state != IDLE) && (lsb ? sh[0] : sh[31]);

`ifdef SPI_XFER_LSB_FIRST_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     lsb <= 1'b0;
      else if (take) lsb <= lsb_first_i;
   end
`else
   assign lsb = 1'b0;
`endif

   // MSB-first words are pre-aligned so bit len sits at bit 31
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len  <= '0;
         cnt  <= '0;
         sh   <= '0;
         rx   <= '0;
         tick <= 1'b0;
      end else begin
         tick <= ((state == SETUP) || (state == HOLD)) ? !tick : 1'b0;
         if (take) begin
            len <= req_len_i;
            cnt <= '0;
            rx  <= '0;
`ifdef SPI_XFER_LSB_FIRST_EN
            sh  <= lsb_first_i ? req_tx_i
                               : req_tx_i << (5'd31 - req_len_i);
`else
            sh  <= req_tx_i << (5'd31 - req_len_i);
`endif
         end else if (state == XFER) begin
            if (cg_rise_i) begin
               cnt <= cnt + 6'd1;
               rx  <= lsb ? (rx | (32'(spi_sdi_i) << cnt[4:0]))
                          : {rx[30:0], spi_sdi_i};
            end
            if (cg_fall_i)
               sh <= lsb ? (sh >> 1) : (sh << 1);
         end
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed scoreboard bench for spi_xfer_ctrl with a behavioural SCK generator.
// Define SPI_XFER_LSB_FIRST_EN to also exercise LSB-first mode.
module tb_spi_xfer_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_len = '0;
   logic [31:0] req_tx = '0;
`ifdef SPI_XFER_LSB_FIRST_EN
   logic        lsb_first = 1'b0;
`endif
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rx;
   logic [7:0]  div = '0;
   logic        div_valid = 1'b0;
   logic [7:0]  cg_div;
   logic        cg_div_valid;
   logic        cg_en;
   logic        cg_rise = 1'b0;
   logic        cg_fall = 1'b0;
   logic        csn;
   logic        sdo;
   logic        sdi;
   logic        busy;
   logic [1:0]  sdi_mode = 2'd0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] expq[$];

   assign sdi = (sdi_mode == 2'd2) ? sdo : sdi_mode[0];

   spi_xfer_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_len_i      (req_len),
      .req_tx_i       (req_tx),
`ifdef SPI_XFER_LSB_FIRST_EN
      .lsb_first_i    (lsb_first),
`endif
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rx_o       (rsp_rx),
      .div_i          (div),
      .div_valid_i    (div_valid),
      .cg_div_o       (cg_div),
      .cg_div_valid_o (cg_div_valid),
      .cg_en_o        (cg_en),
      .cg_rise_i      (cg_rise),
      .cg_fall_i      (cg_fall),
      .spi_csn_o      (csn),
      .spi_sdo_o      (sdo),
      .spi_sdi_i      (sdi),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SCK generator model plus pin monitor, all updated away from the active edge
   int          hp = 2;
   int          ph = 0;
   logic        sck = 1'b0;
   int          rises = 0;
   int          falls = 0;
   logic [31:0] sdo_cap = '0;
   logic        csn_bad = 1'b0;
   logic        prev_csn = 1'b1;
   int          fall_cyc = 0;
   int          gap = -1;

   always @(negedge clk) begin
      logic en;
      en = cg_en;
      if (cg_fall) fall_cyc = cyc;
      cg_rise = 1'b0;
      cg_fall = 1'b0;
      if (prev_csn && !csn) begin
         rises = 0; falls = 0; sdo_cap = '0; csn_bad = 1'b0; gap = -1;
      end
      if (!prev_csn && csn) gap = cyc - fall_cyc;
      prev_csn = csn;
      if (!en) begin
         sck = 1'b0;
         ph  = 0;
      end else begin
         ph++;
         if (ph >= hp) begin
            ph  = 0;
            sck = !sck;
            if (sck) begin
               cg_rise = 1'b1;
               rises++;
               sdo_cap = {sdo_cap[30:0], sdo};
               if (csn) csn_bad = 1'b1;
            end else begin
               cg_fall = 1'b1;
               falls++;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [31:0] mask(input int len);
      logic [32:0] m;
      m = (33'd1 << (len + 1)) - 33'd1;
      return m[31:0];
   endfunction

   task automatic start(input int len, input logic [31:0] tx);
      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_len   = len[4:0];
      req_tx    = tx;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rises(input int k);
      int n;
      n = 0;
      while (rises < k && n < 1000) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk("rise_wait_bound", {31'd0, n < 1000}, 32'd1);
   endtask

   task automatic finish(input string tag, input int len,
                         input logic [31:0] cap, input int hold);
      int n;
      logic [31:0] e;
      n = 0;
      while (!rsp_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      #1;
      chk({tag, "_rsp_bound"}, {31'd0, n < 3000}, 32'd1);
      chk({tag, "_rises"}, rises, len + 1);
      chk({tag, "_falls"}, falls, len + 1);
      chk({tag, "_csn_low"}, {31'd0, csn_bad}, 32'd0);
      chk({tag, "_sck_low"}, {31'd0, sck}, 32'd0);
      chk({tag, "_csn_gap"}, gap, 32'd2);
      chk({tag, "_sdo_seq"}, sdo_cap & mask(len), cap);
      if (expq.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
         e = '0;
      end else begin
         e = expq[0];
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         #1;
         chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
         chk({tag, "_hold_rx"}, rsp_rx, e);
         chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      if (expq.size() != 0) e = expq.pop_front();
      chk({tag, "_rx"}, rsp_rx, e);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
      chk({tag, "_rx_clr"}, rsp_rx, 32'd0);
   endtask

   initial begin
      logic seen;
      div       = 8'd9;
      div_valid = 1'b1;
      #1;
      chk("rst_csn", {31'd0, csn}, 32'd1);
      chk("rst_cg_en", {31'd0, cg_en}, 32'd0);
      chk("rst_sdo", {31'd0, sdo}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_rx", rsp_rx, 32'd0);
      chk("rst_div_valid", {31'd0, cg_div_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      div_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      div       = 8'd4;
      div_valid = 1'b1;
      #1;
      chk("div_idle_valid", {31'd0, cg_div_valid}, 32'd1);
      chk("div_idle_val", {24'd0, cg_div}, 32'd4);
      div_valid = 1'b0;

      sdi_mode = 2'd2;
      expq.push_back(32'h0000_00A5);
      start(7, 32'h0000_00A5);
      wait_rises(2);
      div_valid = 1'b1;
      #1;
      chk("div_xfer_drop", {31'd0, cg_div_valid}, 32'd0);
      chk("busy_xfer", {31'd0, busy}, 32'd1);
      @(negedge clk);
      div_valid = 1'b0;
      finish("loop8", 7, 32'hA5, 0);

      sdi_mode = 2'd1;
      expq.push_back(32'hFFFF_FFFF);
      start(31, 32'hDEAD_BEEF);
      finish("ones32", 31, 32'hDEAD_BEEF, 0);

      sdi_mode = 2'd0;
      expq.push_back(32'h0);
      start(0, 32'h0000_0001);
      finish("one_bit", 0, 32'h1, 0);

      sdi_mode = 2'd2;
      hp = 3;
      expq.push_back(32'h0000_0ABC);
      start(11, 32'h0000_FABC);
      finish("hold12", 11, 32'hABC, 10);
      hp = 2;

      start(15, 32'h0000_1234);
      wait_rises(3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_csn", {31'd0, csn}, 32'd1);
      chk("abort_cg_en", {31'd0, cg_en}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("abort_no_rsp", {31'd0, seen}, 32'd0);

      expq.push_back(32'h0000_003C);
      start(7, 32'h0000_003C);
      finish("after_rst", 7, 32'h3C, 0);

`ifdef SPI_XFER_LSB_FIRST_EN
      lsb_first = 1'b1;
      expq.push_back(32'h0000_0001);
      start(7, 32'h0000_0001);
      lsb_first = 1'b0;
      finish("lsb_first", 7, 32'h80, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL expose clk_i  input  1  sole clock; all state on its rising edge.
REQ-002 SHALL expose rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose req_valid_i  input  1, req_ready_o  output  1  transfer request handshake.
REQ-004 SHALL expose req_len_i  input  5  bit count minus one (0 = 1 bit, 31 = 32 bits).
REQ-005 SHALL expose req_tx_i  input  32  transmit word, bits [len:0] used.
REQ-006 SHALL expose rsp_valid_o  output  1, rsp_ready_i  input  1, rsp_rx_o  output  32  receive word handshake.
REQ-007 SHALL expose div_i  input  8, div_valid_i  input  1  divider update request from register file.
REQ-008 SHALL expose cg_div_o  output  8, cg_div_valid_o  output  1, cg_en_o  output  1  drive to SPI clock generator.
REQ-009 SHALL expose cg_rise_i  input  1, cg_fall_i  input  1  single-cycle SCK edge strobes from clock generator (SCK idles low).
REQ-010 SHALL expose spi_csn_o  output  1, spi_sdo_o  output  1, spi_sdi_i  input  1  SPI pins (mode 0).
REQ-011 SHALL expose busy_o  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, SETUP, XFER, DRAIN, HOLD, RESP.
REQ-013 SHALL assert req_ready_o only in IDLE; handshake = req_valid_i && req_ready_o.
REQ-014 On handshake SHALL latch len, load shift register with req_tx_i, clear rx register to 0, drive spi_csn_o low next cycle, enter SETUP.
REQ-015 spi_sdo_o SHALL present bit req_len_i of tx word (MSB-first) from SETUP entry.
REQ-016 SETUP SHALL last exactly 2 clk_i cycles with cg_en_o low, then enter XFER.
REQ-017 In XFER cg_en_o SHALL be high; on cg_rise_i sample spi_sdi_i into rx bit 0 (rx shifts left) and increment bit counter.
REQ-018 On cg_fall_i in XFER SHALL shift next tx bit onto spi_sdo_o.
REQ-019 When the rise sampling bit len+1 occurs SHALL enter DRAIN; DRAIN keeps cg_en_o high until cg_fall_i, then drops cg_en_o same cycle and enters HOLD.
REQ-020 HOLD SHALL last exactly 2 cycles with spi_csn_o low, then raise spi_csn_o and enter RESP.
REQ-021 RESP SHALL hold rsp_valid_o high and rsp_rx_o stable until rsp_ready_i; then IDLE; rsp_rx_o bits above len read 0.
REQ-022 cg_div_valid_o SHALL equal div_valid_i && IDLE; cg_div_o = div_i; updates outside IDLE are dropped, not queued.
REQ-023 cg_rise_i/cg_fall_i outside XFER/DRAIN SHALL be ignored.
REQ-024 spi_sdo_o SHALL be 0 and spi_csn_o 1 in IDLE.

Reset
REQ-025 On rst_i assertion SHALL immediately (asynchronously) enter IDLE: spi_csn_o=1, cg_en_o=0, spi_sdo_o=0, rsp_valid_o=0, rsp_rx_o=0, cg_div_valid_o=0, busy_o=0, counters 0.
REQ-026 Reset mid-transfer SHALL abort with no response; first request after deassertion SHALL start from clean state.

Configuration
REQ-027 Macro SPI_XFER_LSB_FIRST_EN: when defined, SHALL add input lsb_first_i (1 bit, latched at handshake); if high, tx shifts out bit 0 first and rx bits are placed from bit 0 upward in arrival order... rx first-received bit lands in rsp_rx_o[0].
REQ-028 Without SPI_XFER_LSB_FIRST_EN the port SHALL be absent and behaviour MSB-first only.

Verification
REQ-029 len=7, tx=0xA5, sdi looped to sdo, div=0 -> 8 rises, rsp_rx_o=0x000000A5, csn low for whole transfer, exactly 8 SCK pulses.
REQ-030 len=31, tx=0xDEADBEEF, sdi tied 1 -> rsp_rx_o=0xFFFFFFFF; sdo sequence matches 0xDEADBEEF MSB-first.
REQ-031 len=0, tx bit0=1, sdi=0 -> 1 SCK pulse, rsp_rx_o=0, SCK ends low, csn rises 2 cycles after final fall.
REQ-032 div_valid_i pulsed with div=4 during XFER -> cg_div_valid_o stays 0; same pulse in IDLE -> cg_div_valid_o=1, cg_div_o=4.
REQ-033 rst_i asserted at bit 3 of len=15 transfer -> csn=1, cg_en_o=0 same cycle, no rsp_valid_o; next request len=7 completes correctly.
REQ-034 rsp_ready_i held low 10 cycles -> rsp_valid_o and rsp_rx_o stable, req_ready_o low throughout; with SPI_XFER_LSB_FIRST_EN, lsb_first_i=1, tx=0x01, len=7 -> sdo first bit 1.
